// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared definitions for the PC sequencer.
//   - seq_state_t         : sequencer state encoding (BOOT, RUN, HALTED)
//   - BOOT_VECTOR_DEFAULT : default address loaded into the PC after reset
//   - COUNT_W             : width of the performance counters
package pc_sequencer_pkg;

    localparam logic [31:0] BOOT_VECTOR_DEFAULT = 32'h0000_0000;
    localparam int unsigned COUNT_W             = 16;

    typedef enum logic [1:0] {
        StBoot   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pc_event_counter.sv
// pc_event_counter: event counter with selectable wrap or saturate behaviour.
// Ports:
//   i_clock   in  1      rising-edge clock
//   i_reset_n in  1      asynchronous active-low reset, clears the count
//   i_inc     in  1      count one event this cycle
//   o_count   out WIDTH  current count
module pc_event_counter #(
    parameter int unsigned WIDTH    = 16,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;

    always_comb begin
        w_count_next = r_count;
        if (i_inc) begin
            // All-ones is the ceiling in saturate mode; otherwise let it roll over.
            if (SATURATE && (&r_count)) begin
                w_count_next = r_count;
            end else begin
                w_count_next = r_count + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: chooses the next PC source each cycle (boot, halt, branch, jump,
// hold or sequential) and keeps redirect/stall performance counters.
// Ports:
//   clock, reset                  single clock; asynchronous active-low reset
//   control_branch_taken/target   EX-stage taken branch and its target
//   control_jump/data_jump_target ID-stage jump and its target
//   control_stall, imem_ready     hold requests (hazard unit, instruction memory)
//   control_halt, control_resume  halt / resume requests
//   data_current_address          PC feedback
//   control_use_npc               1 = PC+4, 0 = load data_jump_address
//   data_jump_address             address loaded when control_use_npc = 0
//   control_flush                 kill IF/ID, registered, one cycle per redirect
//   control_halted                sequencer is in HALTED
//   data_redirect_count           applied branches/jumps (wraps)
//   data_stall_count              RUN-state hold cycles (saturates)
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] BOOT_VECTOR = BOOT_VECTOR_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               control_branch_taken,
    input  logic [31:0]        data_branch_target,
    input  logic               control_jump,
    input  logic [31:0]        data_jump_target,
    input  logic               control_stall,
    input  logic               control_imem_ready,
    input  logic               control_halt,
    input  logic               control_resume,
    input  logic [31:0]        data_current_address,
    output logic               control_use_npc,
    output logic [31:0]        data_jump_address,
    output logic               control_flush,
    output logic               control_halted,
    output logic [COUNT_W-1:0] data_redirect_count,
    output logic [COUNT_W-1:0] data_stall_count
);

    seq_state_t r_state;
    seq_state_t w_state_next;
    logic       r_flush;
    logic       w_redirect;
    logic       w_hold_cycle;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= StBoot;
            r_flush <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_flush <= w_redirect;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        control_use_npc   = 1'b0;
        data_jump_address = data_current_address;
        w_redirect        = 1'b0;
        w_hold_cycle      = 1'b0;
        unique case (r_state)
            StBoot: begin
                data_jump_address = BOOT_VECTOR;
                w_state_next      = StRun;
            end
            StRun: begin
                // Halt wins and swallows any redirect presented in the same cycle.
                if (control_halt) begin
                    w_state_next = StHalted;
                end else if (control_branch_taken) begin
                    data_jump_address = data_branch_target;
                    w_redirect        = 1'b1;
                end else if (control_jump) begin
                    data_jump_address = data_jump_target;
                    w_redirect        = 1'b1;
                end else if (control_stall || !control_imem_ready) begin
                    w_hold_cycle = 1'b1;
                end else begin
                    control_use_npc = 1'b1;
                end
            end
            StHalted: begin
                if (control_resume && !control_halt) begin
                    w_state_next = StRun;
                end
            end
            default: begin
                data_jump_address = BOOT_VECTOR;
                w_state_next      = StBoot;
            end
        endcase
    end

    assign control_flush  = r_flush;
    assign control_halted = (r_state == StHalted);

    pc_event_counter #(
        .WIDTH    (COUNT_W),
        .SATURATE (1'b0)
    ) u_redirect_cnt (
        .i_clock   (clock),
        .i_reset_n (reset),
        .i_inc     (w_redirect),
        .o_count   (data_redirect_count)
    );

    pc_event_counter #(
        .WIDTH    (COUNT_W),
        .SATURATE (1'b1)
    ) u_stall_cnt (
        .i_clock   (clock),
        .i_reset_n (reset),
        .i_inc     (w_hold_cycle),
        .o_count   (data_stall_count)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer with a small external PC model.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        control_branch_taken;
    logic [31:0] data_branch_target;
    logic        control_jump;
    logic [31:0] data_jump_target;
    logic        control_stall;
    logic        control_imem_ready;
    logic        control_halt;
    logic        control_resume;
    logic [31:0] data_current_address;
    logic        control_use_npc;
    logic [31:0] data_jump_address;
    logic        control_flush;
    logic        control_halted;
    logic [15:0] data_redirect_count;
    logic [15:0] data_stall_count;

    int n_cmp = 0;
    int n_err = 0;

    // PC register model; no reset so reset-time outputs differ from the feedback.
    logic [31:0] r_pc = 32'hDEAD_0000;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        r_pc <= control_use_npc ? r_pc + 32'd4 : data_jump_address;
    end

    assign data_current_address = r_pc;

    pc_sequencer #(
        .BOOT_VECTOR (32'h0000_0000)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .control_branch_taken (control_branch_taken),
        .data_branch_target   (data_branch_target),
        .control_jump         (control_jump),
        .data_jump_target     (data_jump_target),
        .control_stall        (control_stall),
        .control_imem_ready   (control_imem_ready),
        .control_halt         (control_halt),
        .control_resume       (control_resume),
        .data_current_address (data_current_address),
        .control_use_npc      (control_use_npc),
        .data_jump_address    (data_jump_address),
        .control_flush        (control_flush),
        .control_halted       (control_halted),
        .data_redirect_count  (data_redirect_count),
        .data_stall_count     (data_stall_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_req();
        control_branch_taken = 1'b0;
        control_jump         = 1'b0;
        control_stall        = 1'b0;
        control_imem_ready   = 1'b1;
        control_halt         = 1'b0;
        control_resume       = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset              = 1'b0;
        data_branch_target = 32'h0;
        data_jump_target   = 32'h0;
        clear_req();

        // Reset state before any edge
        #2;
        check("rst_use_npc",  32'(control_use_npc), 32'h0);
        check("rst_jaddr",    data_jump_address, 32'h0);
        check("rst_halted",   32'(control_halted), 32'h0);
        check("rst_flush",    32'(control_flush), 32'h0);
        check("rst_redir",    32'(data_redirect_count), 32'h0);
        check("rst_stall",    32'(data_stall_count), 32'h0);

        // Release between edges; first cycle is BOOT
        #10;
        reset = 1'b1;
        #1;
        check("boot_use_npc", 32'(control_use_npc), 32'h0);
        tick();
        check("seq_pc0",      r_pc, 32'h0);
        check("seq_use_npc",  32'(control_use_npc), 32'h1);
        tick();
        check("seq_pc4",      r_pc, 32'h4);
        tick();
        check("seq_pc8",      r_pc, 32'h8);

        // Branch beats simultaneous jump
        control_branch_taken = 1'b1;
        data_branch_target   = 32'h40;
        control_jump         = 1'b1;
        data_jump_target     = 32'h80;
        #1;
        check("br_jaddr",     data_jump_address, 32'h40);
        tick();
        check("br_pc",        r_pc, 32'h40);
        check("br_flush",     32'(control_flush), 32'h1);
        check("br_redir",     32'(data_redirect_count), 32'h1);

        // Three stall cycles
        clear_req();
        control_stall = 1'b1;
        tick();
        check("st_flush_off", 32'(control_flush), 32'h0);
        tick();
        tick();
        check("st_pc",        r_pc, 32'h40);
        check("st_cnt",       32'(data_stall_count), 32'h3);
        control_stall = 1'b0;
        tick();
        check("st_release",   r_pc, 32'h44);

        // Branch while imem not ready, then back-to-back jump
        control_imem_ready   = 1'b0;
        control_branch_taken = 1'b1;
        data_branch_target   = 32'h200;
        tick();
        check("br_nrdy_pc",   r_pc, 32'h200);
        check("br_nrdy_cnt",  32'(data_stall_count), 32'h3);
        control_imem_ready   = 1'b1;
        control_branch_taken = 1'b0;
        control_jump         = 1'b1;
        data_jump_target     = 32'h300;
        tick();
        check("jmp_pc",       r_pc, 32'h300);
        check("b2b_flush",    32'(control_flush), 32'h1);
        check("jmp_redir",    32'(data_redirect_count), 32'h3);
        clear_req();
        control_imem_ready = 1'b0;
        tick();
        check("nrdy_pc",      r_pc, 32'h300);
        check("nrdy_flush",   32'(control_flush), 32'h0);
        check("nrdy_cnt",     32'(data_stall_count), 32'h4);

        // Halt with simultaneous branch: branch is discarded
        clear_req();
        control_halt         = 1'b1;
        control_branch_taken = 1'b1;
        data_branch_target   = 32'h100;
        #1;
        check("halt_jaddr",   data_jump_address, 32'h300);
        tick();
        check("halt_pc",      r_pc, 32'h300);
        check("halt_flag",    32'(control_halted), 32'h1);
        check("halt_redir",   32'(data_redirect_count), 32'h3);
        check("halt_flush",   32'(control_flush), 32'h0);
        control_branch_taken = 1'b0;
        control_resume       = 1'b1;
        control_stall        = 1'b1;
        tick();
        check("hr_both",      32'(control_halted), 32'h1);
        check("hr_pc",        r_pc, 32'h300);
        check("hr_stall_cnt", 32'(data_stall_count), 32'h4);
        control_halt  = 1'b0;
        control_stall = 1'b0;
        tick();
        check("resume_flag",  32'(control_halted), 32'h0);
        check("resume_pc",    r_pc, 32'h300);
        control_resume = 1'b0;
        tick();
        check("resume_adv",   r_pc, 32'h304);

        // Stall counter saturates
        force dut.u_stall_cnt.r_count = 16'hFFFE;
        #1;
        release dut.u_stall_cnt.r_count;
        check("sat_preload",  32'(data_stall_count), 32'hFFFE);
        control_stall = 1'b1;
        tick();
        check("sat_ffff",     32'(data_stall_count), 32'hFFFF);
        tick();
        tick();
        check("sat_hold",     32'(data_stall_count), 32'hFFFF);
        control_stall = 1'b0;

        // Redirect counter wraps
        force dut.u_redirect_cnt.r_count = 16'hFFFF;
        #1;
        release dut.u_redirect_cnt.r_count;
        control_jump     = 1'b1;
        data_jump_target = 32'h500;
        tick();
        check("wrap_cnt",     32'(data_redirect_count), 32'h0);
        check("wrap_pc",      r_pc, 32'h500);
        data_jump_target = 32'h600;
        tick();
        check("wrap_cnt1",    32'(data_redirect_count), 32'h1);

        // Halt, then reset mid-cycle with a branch pending
        clear_req();
        control_halt = 1'b1;
        tick();
        check("h2_flag",      32'(control_halted), 32'h1);
        control_halt         = 1'b0;
        control_branch_taken = 1'b1;
        data_branch_target   = 32'h700;
        #2;
        reset = 1'b0;
        #1;
        check("mr_use_npc",   32'(control_use_npc), 32'h0);
        check("mr_jaddr",     data_jump_address, 32'h0);
        check("mr_halted",    32'(control_halted), 32'h0);
        check("mr_redir",     32'(data_redirect_count), 32'h0);
        check("mr_stall",     32'(data_stall_count), 32'h0);
        tick();
        check("mr_pc",        r_pc, 32'h0);
        reset = 1'b1;
        #1;
        check("mr_boot_jaddr", data_jump_address, 32'h0);
        control_branch_taken = 1'b0;
        tick();
        check("mr_boot_pc",   r_pc, 32'h0);
        tick();
        check("mr_run_pc",    r_pc, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter BOOT_VECTOR, default 32'h0000_0000, address loaded into the PC after reset.
REQ-002 SHALL have port clock  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port control_branch_taken  in  1  EX-stage branch resolved taken.
REQ-005 SHALL have port data_branch_target  in  32  branch target address.
REQ-006 SHALL have port control_jump  in  1  ID-stage jump decoded.
REQ-007 SHALL have port data_jump_target  in  32  jump target address.
REQ-008 SHALL have port control_stall  in  1  hazard unit requests the PC be held.
REQ-009 SHALL have port control_imem_ready  in  1  instruction memory can accept a fetch.
REQ-010 SHALL have port control_halt / control_resume  in  1 each  halt and resume requests.
REQ-011 SHALL have port data_current_address  in  32  current PC instruction_address (feedback).
REQ-012 SHALL have port control_use_npc  out  1  1 = PC advances to PC+4; 0 = PC loads data_jump_address.
REQ-013 SHALL have port data_jump_address  out  32  address the PC loads when control_use_npc=0.
REQ-014 SHALL have port control_flush  out  1  kill the instruction in IF/ID.
REQ-015 SHALL have port control_halted  out  1  sequencer is in HALTED.
REQ-016 SHALL have ports data_redirect_count and data_stall_count  out  16 each  performance counters.

Function
REQ-017 SHALL implement states BOOT, RUN and HALTED.
REQ-018 BOOT SHALL drive use_npc=0 and jump_address=BOOT_VECTOR, then go to RUN unconditionally on the next edge.
REQ-019 In RUN, the per-cycle decision SHALL be combinational from state and inputs with priority halt > branch > jump > hold > sequential.
REQ-020 halt: use_npc=0, jump_address=data_current_address; next state HALTED; any simultaneous branch or jump SHALL be discarded.
REQ-021 branch: use_npc=0, jump_address=data_branch_target; applies even while control_stall=1 or control_imem_ready=0.
REQ-022 jump: use_npc=0, jump_address=data_jump_target; applies only when control_branch_taken=0.
REQ-023 hold (control_stall=1 or control_imem_ready=0, with no redirect): use_npc=0, jump_address=data_current_address.
REQ-024 sequential: use_npc=1, jump_address=data_current_address.
REQ-025 HALTED SHALL hold the PC as in the hold case (REQ-023) and go to RUN on the edge where control_resume=1 and control_halt=0; if both are high, it SHALL remain HALTED.
REQ-026 control_flush SHALL be registered and high for exactly one cycle after each edge at which a branch or jump was applied; back-to-back redirects SHALL keep it high.
REQ-027 data_redirect_count SHALL increment by 1 per applied branch or jump and wrap from 16'hFFFF to 0.
REQ-028 data_stall_count SHALL increment per RUN-state hold cycle and saturate at 16'hFFFF.
REQ-029 control_halted SHALL equal (state==HALTED).

Reset
REQ-030 Reset assertion SHALL immediately force state=BOOT, control_flush=0 and both counters=0.
REQ-031 During reset, outputs SHALL be use_npc=0, jump_address=BOOT_VECTOR and control_halted=0.
REQ-032 Reset mid-operation, including in HALTED, SHALL abandon any pending decision and restart at BOOT.

Structure
REQ-033 State encodings and the BOOT_VECTOR default SHALL reside in the shared MIPS definitions package.
REQ-034 Both counters SHALL instantiate one sub-module, pc_event_counter, with a 16-bit width and a SATURATE parameter (0 = wrap, 1 = saturate).

Verification
REQ-035 Reset release, no requests, feedback from the pc model -> PC reads 0, 4, 8; use_npc=1 from the second cycle.
REQ-036 At PC=8, branch_taken=1 with target 0x40, jump=1 with target 0x80, in the same cycle -> PC=0x40, flush high one cycle, redirect_count=1.
REQ-037 stall=1 for 3 cycles at PC=0x40 -> PC stays 0x40, stall_count=3; on release, PC=0x44.
REQ-038 halt=1 together with branch_taken=1 (target 0x100) -> PC holds, halted=1, redirect_count unchanged; halt and resume both high -> stays halted; resume=1 alone -> PC advances by 4.
REQ-039 Hold stall_count at 16'hFFFE and stall 3 more cycles -> stall_count=16'hFFFF; redirect_count at 16'hFFFF plus one jump -> redirect_count=0.
REQ-040 Assert reset mid-branch while in HALTED -> immediate BOOT outputs and counters=0; PC returns to BOOT_VECTOR after release.
